// File: rtl/stopwatch_digit_scan.sv
// HH:MM:SS.cc BCD stopwatch that presents one digit at a time on v/anum for the downstream decoder.
// Optional lap-hold display (lap port plus snapshot registers) is built only when LAP_HOLD_EN is defined.
module stopwatch_digit_scan #(
   parameter int CLK_HZ  = 100000000,
   parameter int TICK_HZ = 100,
   parameter int SCAN_HZ = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_stop,
   input  logic       clear,
`ifdef LAP_HOLD_EN
   input  logic       lap,
`endif
   output logic [3:0] v,
   output logic [2:0] anum,
   output logic       running,
   output logic       overflow
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              clear_time;
   logic              tick_rst;
   logic              tick;
   logic [TICK_W-1:0] tick_cnt;
   logic [SCAN_W-1:0] scan_cnt;
   logic [31:0]       digits;
   logic [31:0]       digits_nxt;
   logic [8:0]        carry;
   logic              wrap;
   logic [31:0]       shown;

   // Seconds tens and minutes tens roll over at 5; every other digit at 9.
   function automatic logic [3:0] digit_max(input int idx);
      return ((idx == 3) || (idx == 5)) ? 4'd5 : 4'd9;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == RUN);
      end
   end

   // In RUN start_stop has priority and clear is ignored; elsewhere clear has priority.
   always_comb begin
      state_nxt  = state;
      clear_time = 1'b0;
      tick_rst   = 1'b0;
      case (state)
         IDLE: begin
            if (!clear && start_stop) begin
               state_nxt = RUN;
               tick_rst  = 1'b1;
            end
         end
         RUN: begin
            if (start_stop) begin
               state_nxt = PAUSE;
            end
         end
         PAUSE: begin
            if (clear) begin
               state_nxt  = IDLE;
               clear_time = 1'b1;
               tick_rst   = 1'b1;
            end else if (start_stop) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign tick = (state == RUN) && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (tick_rst || tick) begin
         tick_cnt <= '0;
      end else if (state == RUN) begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Ripple the tick through all eight digits in one cycle.
   always_comb begin
      digits_nxt = digits;
      carry      = '0;
      carry[0]   = tick;
      for (int i = 0; i < 8; i++) begin
         if (carry[i]) begin
            if (digits[4*i +: 4] == digit_max(i)) begin
               digits_nxt[4*i +: 4] = 4'd0;
               carry[i+1]           = 1'b1;
            end else begin
               digits_nxt[4*i +: 4] = digits[4*i +: 4] + 4'd1;
            end
         end
      end
      if (clear_time) begin
         digits_nxt = '0;
      end
   end

   assign wrap = carry[8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits <= '0;
      end else begin
         digits <= digits_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (clear && (state != RUN)) begin
         overflow <= 1'b0;
      end else if (wrap) begin
         overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         anum     <= 3'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         anum     <= anum + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

`ifdef LAP_HOLD_EN
   logic        hold;
   logic [31:0] snap;

   // The snapshot is the registered time during the lap cycle, before that cycle's tick lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold <= 1'b0;
         snap <= '0;
      end else if ((state_nxt != RUN) || clear) begin
         hold <= 1'b0;
      end else if (lap && (state == RUN)) begin
         hold <= ~hold;
         if (!hold) begin
            snap <= digits;
         end
      end
   end

   assign shown = hold ? snap : digits;
`else
   assign shown = digits;
`endif

   assign v = shown[{anum, 2'b00} +: 4];

endmodule

// File: tb/tb_stopwatch_digit_scan.sv
// Randomized self-checking bench for stopwatch_digit_scan, checked against a centisecond-count model.
// Lap-hold checks are compiled in only when LAP_HOLD_EN is defined.
`timescale 1ns/1ps
module tb_stopwatch_digit_scan;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int SCAN_HZ = 250;
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned FULL_CS = 36000000;

   typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_t;

   logic       clk;
   logic       rst_n;
   logic       start_stop;
   logic       clear;
`ifdef LAP_HOLD_EN
   logic       lap;
`endif
   logic [3:0] v;
   logic [2:0] anum;
   logic       running;
   logic       overflow;

   int          checks;
   int          fails;
   int          scan_edges;
   int unsigned model_cs;
   int          model_p;
   logic        model_ovf;
   mstate_t     model_state;
   logic [31:0] lastTime;

   stopwatch_digit_scan #(
      .CLK_HZ (CLK_HZ),
      .TICK_HZ(TICK_HZ),
      .SCAN_HZ(SCAN_HZ)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_stop(start_stop),
      .clear     (clear),
`ifdef LAP_HOLD_EN
      .lap       (lap),
`endif
      .v         (v),
      .anum      (anum),
      .running   (running),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts clock edges since reset release; the scan index is simply this count divided down.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) scan_edges <= 0;
      else        scan_edges <= scan_edges + 1;
   end

   function automatic logic [31:0] to_bcd(input int unsigned cs);
      int unsigned h, m, s, c;
      h = cs / 360000;
      m = (cs / 6000) % 60;
      s = (cs / 100) % 60;
      c = cs % 100;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
              4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Advance the model by k clock edges spent in RUN.
   task advance(input int k);
      int total;
      total    = model_p + k;
      model_cs = model_cs + int'(total / TICK_DIV);
      if (model_cs >= FULL_CS) begin
         model_cs  = model_cs - FULL_CS;
         model_ovf = 1'b1;
      end
      model_p = total % TICK_DIV;
   endtask

   task enterRun();
      if (model_state == M_IDLE) model_p = 0;
      model_state = M_RUN;
   endtask

   // Pulse the given inputs for one edge, then idle for 'idle' more edges.
   task applyStimulus(input logic ss, input logic clr, input int idle);
      start_stop = ss;
      clear      = clr;
      @(negedge clk);
      start_stop = 1'b0;
      clear      = 1'b0;
      repeat (idle) @(negedge clk);
   endtask

   task runSegment(input int k);
      enterRun();
      applyStimulus(1'b1, 1'b0, k - 1);
      applyStimulus(1'b1, 1'b0, 0);
      advance(k);
      model_state = M_PAUSE;
   endtask

   task runWithClear(input int a, input int b);
      enterRun();
      applyStimulus(1'b1, 1'b0, a);
      applyStimulus(1'b0, 1'b1, b);
      applyStimulus(1'b1, 1'b0, 0);
      advance(a + b + 2);
      model_state = M_PAUSE;
   endtask

   task clearPulse();
      applyStimulus(1'b0, 1'b1, 0);
      model_ovf = 1'b0;
      if (model_state == M_PAUSE) begin
         model_state = M_IDLE;
         model_cs    = 0;
         model_p     = 0;
      end
   endtask

   task preload(input logic [31:0] bcd, input int unsigned cs);
      force dut.digits_nxt = bcd;
      @(posedge clk);
      #1;
      release dut.digits_nxt;
      @(negedge clk);
      model_cs = cs;
   endtask

   task readTime(output logic [31:0] t);
      int a;
      t = '0;
      for (int i = 0; i < 8 * SCAN_DIV; i++) begin
         a = (scan_edges / SCAN_DIV) % 8;
         checkOutput("anum", 32'(anum), 32'(a));
         t[a*4 +: 4] = v;
         @(negedge clk);
      end
   endtask

   task checkTime(input string tag);
      readTime(lastTime);
      checkOutput({tag, "_time"}, lastTime, to_bcd(model_cs));
      checkOutput({tag, "_running"}, 32'(running), 32'(model_state == M_RUN));
      checkOutput({tag, "_overflow"}, 32'(overflow), 32'(model_ovf));
   endtask

   task modelReset();
      model_cs    = 0;
      model_p     = 0;
      model_ovf   = 1'b0;
      model_state = M_IDLE;
   endtask

   initial begin
      int sel;
      int k;
      checks     = 0;
      fails      = 0;
      rst_n      = 1'b0;
      start_stop = 1'b0;
      clear      = 1'b0;
`ifdef LAP_HOLD_EN
      lap        = 1'b0;
`endif
      modelReset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      checkOutput("rst_anum", 32'(anum), 32'd0);
      checkOutput("rst_v", 32'(v), 32'd0);
      checkOutput("rst_running", 32'(running), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      applyStimulus(1'b0, 1'b0, 8);
      checkTime("idle");

      runSegment(100);
      checkTime("run100");
      checkOutput("run100_literal", lastTime, 32'h0000_0010);
      applyStimulus(1'b0, 1'b0, 50);
      checkTime("paused");

      preload(32'h0000_5999, 5999);
      runSegment(TICK_DIV - model_p);
      checkTime("minute_carry");
      checkOutput("minute_literal", lastTime, 32'h0001_0000);

      preload(32'h9959_5999, FULL_CS - 1);
      runSegment(TICK_DIV - model_p);
      checkTime("wrap");
      checkOutput("wrap_literal", lastTime, 32'h0000_0000);
      checkOutput("wrap_ovf_literal", 32'(overflow), 32'd1);
      runSegment(25);
      checkTime("after_wrap");
      clearPulse();
      checkTime("cleared");

      // start_stop with clear: clear is dropped in RUN but wins in PAUSE.
      k = 37;
      enterRun();
      applyStimulus(1'b1, 1'b0, k - 1);
      applyStimulus(1'b1, 1'b1, 0);
      advance(k);
      model_state = M_PAUSE;
      checkTime("both_in_run");
      applyStimulus(1'b1, 1'b1, 0);
      modelReset();
      applyStimulus(1'b0, 1'b0, 20);
      checkTime("both_in_pause");

      for (int it = 0; it < 14; it++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            3:       runWithClear(int'($urandom_range(0, 30)), int'($urandom_range(0, 30)));
            4: begin
               if (model_state == M_PAUSE) clearPulse();
               else runSegment(int'($urandom_range(1, 60)));
            end
            default: runSegment(int'($urandom_range(1, 60)));
         endcase
         checkTime("rand");
      end

      applyStimulus(1'b1, 1'b0, 23);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_anum", 32'(anum), 32'd0);
      checkOutput("midrst_v", 32'(v), 32'd0);
      checkOutput("midrst_running", 32'(running), 32'd0);
      checkOutput("midrst_overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      checkTime("midrst");

`ifdef LAP_HOLD_EN
      begin
         int          a;
         logic [31:0] bcd;
         logic [31:0] held;
         enterRun();
         applyStimulus(1'b1, 1'b0, 50);
         lap = 1'b1;
         @(negedge clk);
         lap = 1'b0;
         checkOutput("lap_running", 32'(running), 32'd1);
         readTime(held);
         checkOutput("lap_hold", held, to_bcd(5));
         lap = 1'b1;
         @(negedge clk);
         lap = 1'b0;
         for (int n = 84; n < 92; n++) begin
            a   = (scan_edges / SCAN_DIV) % 8;
            bcd = to_bcd(int'(n / TICK_DIV));
            checkOutput("lap_live", 32'(v), 32'(bcd[a*4 +: 4]));
            @(negedge clk);
         end
         applyStimulus(1'b1, 1'b0, 0);
         advance(93);
         model_state = M_PAUSE;
         checkTime("lap_pause");
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
